// File: rtl/fir_decim_pkg.sv
`default_nettype none
// ============================================================================
// fir_decim_pkg - shared types and width/rounding helpers for fir_decim_mc
// Revision: 1.0
// ============================================================================
package fir_decim_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  function automatic int acc_width(input int dw, input int cw, input int nt);
    return dw + cw + clog2(nt);
  endfunction

  // Room for N_TAPS history plus the DECIM-1 samples that may arrive mid-pass.
  function automatic int depth_of(input int nt, input int dec);
    return 1 << clog2(nt + dec);
  endfunction

  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int shift, input int out_w);
    logic signed [63:0] r;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    r = acc;
    if (shift > 0) r = r + (64'sd1 <<< (shift - 1));
    r = r >>> shift;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    if (r > max_v) r = max_v;
    else if (r < min_v) r = min_v;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_tap_ram.sv
`default_nettype none
// ============================================================================
// fir_tap_ram - one-write / one-registered-read delay-line RAM, cleared on reset
// Revision: 1.0
// ============================================================================
module fir_tap_ram #(
  parameter int W     = 12,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/fir_decim_mc.sv
`default_nettype none
// ============================================================================
// fir_decim_mc - multi-channel decimating FIR, one time-shared MAC
// Revision: 1.0
// ============================================================================
module fir_decim_mc
  import fir_decim_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int COEF_W   = 16,
  parameter int N_TAPS   = 32,
  parameter int DECIM    = 4,
  parameter int CHANNELS = 2,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic                         out_valid,
  output logic [CHANNELS*OUT_W-1:0]    out_data,
  input  logic                         coef_we,
  input  logic [clog2(N_TAPS)-1:0]     coef_addr,
  input  logic [COEF_W-1:0]            coef_data,
  output logic                         coef_ready,
  output logic                         busy
);

  localparam int ACC_W = acc_width(DATA_W, COEF_W, N_TAPS);
  localparam int DEPTH = depth_of(N_TAPS, DECIM);
  localparam int AW    = clog2(DEPTH);
  localparam int TAP_W = clog2(N_TAPS);
  localparam int CH_W  = (CHANNELS > 1) ? clog2(CHANNELS) : 1;
  localparam int PH_W  = (DECIM > 1) ? clog2(DECIM) : 1;
  localparam int P_W   = DATA_W + COEF_W;
  localparam logic signed [COEF_W-1:0] COEF0_RST =
    (SHIFT >= COEF_W - 1) ? {1'b0, {(COEF_W-1){1'b1}}} : COEF_W'(1 << SHIFT);

  state_t                    state_q;
  logic                      pend_q;
  logic [PH_W-1:0]           phase_q;
  logic [AW-1:0]             wr_ptr_q;
  logic [AW-1:0]             base_q;
  logic [TAP_W-1:0]          tap_q;
  logic [CH_W-1:0]           ch_q;
  logic                      flush_q;
  logic signed [COEF_W-1:0]  coef_q [N_TAPS];
  logic                      s1_vld_q, s1_first_q;
  logic [CH_W-1:0]           s1_ch_q;
  logic signed [COEF_W-1:0]  s1_coef_q;
  logic                      s2_vld_q, s2_first_q;
  logic [CH_W-1:0]           s2_ch_q;
  logic signed [P_W-1:0]     prod_q, prod_d;
  logic signed [ACC_W-1:0]   acc_q [CHANNELS];
  logic                      out_valid_q;
  logic [CHANNELS*OUT_W-1:0] out_data_q;
  logic [DATA_W-1:0]         rd_data [CHANNELS];
  logic                      accept, trigger, last_phase;
  logic [AW-1:0]             rd_addr;

  // pend_q covers the one cycle between trigger and RUN so DECIM=1 cannot double-trigger.
  assign busy       = (state_q != S_IDLE);
  assign last_phase = (phase_q == PH_W'(DECIM - 1));
  assign in_ready   = !((busy || pend_q) && last_phase);
  assign coef_ready = !busy;
  assign accept     = in_valid && in_ready;
  assign trigger    = accept && last_phase;
  assign rd_addr    = base_q - AW'(tap_q);
  assign prod_d     = P_W'($signed(rd_data[s1_ch_q])) * P_W'(s1_coef_q);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_line
      fir_tap_ram #(.W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_line (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (accept),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (in_data[c*DATA_W +: DATA_W]),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data[c])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= '0;
      wr_ptr_q <= '0;
      base_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        phase_q  <= last_phase ? '0 : phase_q + PH_W'(1);
      end
      if (trigger) begin
        base_q <= wr_ptr_q;
        pend_q <= 1'b1;
      end else if (state_q == S_IDLE) begin
        pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_TAPS; k++) coef_q[k] <= (k == 0) ? COEF0_RST : '0;
    end else if (coef_we && coef_ready) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  // Read -> multiply -> accumulate; the first tap of a channel reloads its accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_coef_q  <= '0;
      s2_vld_q   <= 1'b0;
      s2_first_q <= 1'b0;
      s2_ch_q    <= '0;
      prod_q     <= '0;
      for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
    end else begin
      s1_vld_q   <= (state_q == S_RUN);
      s1_first_q <= (tap_q == '0);
      s1_ch_q    <= ch_q;
      s1_coef_q  <= coef_q[tap_q];
      s2_vld_q   <= s1_vld_q;
      s2_first_q <= s1_first_q;
      s2_ch_q    <= s1_ch_q;
      prod_q     <= prod_d;
      if (s2_vld_q)
        acc_q[s2_ch_q] <= s2_first_q ? ACC_W'(prod_q) : acc_q[s2_ch_q] + ACC_W'(prod_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tap_q       <= '0;
      ch_q        <= '0;
      flush_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pend_q) begin
            state_q <= S_RUN;
            tap_q   <= '0;
            ch_q    <= '0;
          end
        end
        S_RUN: begin
          if (tap_q == TAP_W'(N_TAPS - 1)) begin
            tap_q <= '0;
            if (ch_q == CH_W'(CHANNELS - 1)) begin
              state_q <= S_FLUSH;
              flush_q <= 1'b0;
            end else begin
              ch_q <= ch_q + CH_W'(1);
            end
          end else begin
            tap_q <= tap_q + TAP_W'(1);
          end
        end
        S_FLUSH: begin
          if (flush_q) state_q <= S_OUT;
          else flush_q <= 1'b1;
        end
        S_OUT: begin
          out_valid_q <= 1'b1;
          for (int c = 0; c < CHANNELS; c++)
            out_data_q[c*OUT_W +: OUT_W] <= OUT_W'(round_sat(64'(acc_q[c]), SHIFT, OUT_W));
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_decim_mc.sv
`default_nettype none
// ============================================================================
// tb_fir_decim_mc - randomized scoreboard bench with a history-based FIR model
// Revision: 1.0
// ============================================================================
module tb_fir_decim_mc;

  localparam int DATA_W   = 12;
  localparam int COEF_W   = 16;
  localparam int N_TAPS   = 32;
  localparam int DECIM    = 4;
  localparam int CHANNELS = 2;
  localparam int OUT_W    = 16;
  localparam int SHIFT    = 15;
  localparam int NC       = N_TAPS * CHANNELS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] in_data = '0;
  logic        coef_we = 1'b0;
  logic [4:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;
  logic        in_ready, out_valid, coef_ready, busy;
  logic [31:0] out_data;

  always #5 clk = ~clk;

  fir_decim_mc #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .N_TAPS(N_TAPS), .DECIM(DECIM),
    .CHANNELS(CHANNELS), .OUT_W(OUT_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_ready(coef_ready), .busy(busy)
  );

  typedef struct packed {
    logic [63:0] due;
    logic [31:0] data;
  } exp_t;

  int      errs = 0;
  int      checks = 0;
  longint  cyc = 0;
  int      mcoef [N_TAPS];
  int      hist [CHANNELS][$];
  int      mphase;
  longint  pt = -1000;
  bit      rst_seen = 1'b0;
  bit      mb;
  exp_t    q [$];
  exp_t    mon_e;
  logic [31:0] last_out = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp_v);
    checks++;
    if (act !== exp_v) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp_v, cyc);
    end
  endtask

  function automatic int coef_rst(input int k);
    int cmax;
    cmax = (1 << (COEF_W - 1)) - 1;
    if (k != 0) return 0;
    return ((1 << SHIFT) > cmax) ? cmax : (1 << SHIFT);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N_TAPS; k++) mcoef[k] = coef_rst(k);
    for (int c = 0; c < CHANNELS; c++) hist[c].delete();
    mphase = 0;
    pt = -1000;
    q.delete();
    last_out = '0;
  endtask

  // y_c = sat(round(sum_k coef[k] * x_c[n-1-k] / 2^SHIFT)), samples before reset are 0
  function automatic logic signed [OUT_W-1:0] ref_out(input int c);
    longint s;
    longint lim;
    int n;
    s = 0;
    n = hist[c].size();
    for (int k = 0; k < N_TAPS; k++)
      if (n - 1 - k >= 0) s += longint'(mcoef[k]) * longint'(hist[c][n-1-k]);
    if (SHIFT > 0) s += longint'(1) << (SHIFT - 1);
    s = s >>> SHIFT;
    lim = longint'(1) << (OUT_W - 1);
    if (s > lim - 1) s = lim - 1;
    if (s < -lim) s = -lim;
    return s[OUT_W-1:0];
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      if (!rst_seen) begin
        rst_seen = 1'b1;
        check("reset out_valid", longint'(out_valid), 0);
        check("reset out_data", longint'(out_data), 0);
        check("reset in_ready", longint'(in_ready), 1);
        check("reset coef_ready", longint'(coef_ready), 1);
        check("reset busy", longint'(busy), 0);
      end
    end else begin
      rst_seen = 1'b0;
      mb = (cyc >= pt + 1) && (cyc <= pt + NC + 3);
      check("busy", longint'(busy), longint'(mb));
      check("coef_ready", longint'(coef_ready), longint'(!mb));
      check("in_ready", longint'(in_ready), longint'(!(mb && mphase == DECIM - 1)));
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected out_valid: got 1 expected 0 at cycle %0d", cyc);
        end else begin
          mon_e = q.pop_front();
          check("latency", cyc, longint'(mon_e.due));
          check("out ch0", longint'($signed(out_data[15:0])), longint'($signed(mon_e.data[15:0])));
          check("out ch1", longint'($signed(out_data[31:16])), longint'($signed(mon_e.data[31:16])));
          last_out = mon_e.data;
        end
      end else begin
        check("out_data hold", longint'(out_data), longint'(last_out));
        if (q.size() > 0 && longint'(q[0].due) < cyc) begin
          checks++;
          errs++;
          $display("FAIL missing out_valid: got none expected at cycle %0d", q[0].due);
          void'(q.pop_front());
        end
      end
      if (coef_we && !mb) mcoef[coef_addr] = int'($signed(coef_data));
      if (in_valid && in_ready) begin
        hist[0].push_back(int'($signed(in_data[11:0])));
        hist[1].push_back(int'($signed(in_data[23:12])));
        mphase++;
        if (mphase == DECIM) begin
          mphase = 0;
          mon_e.data = {ref_out(1), ref_out(0)};
          mon_e.due  = 64'(cyc + 1 + NC + 4);
          q.push_back(mon_e);
          pt = cyc + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input int gap,
                      input bit wc, input int caddr, input int cdata);
    int guard;
    bit w;
    logic [31:0] av, bv, ca, cd;
    av = a; bv = b; ca = caddr; cd = cdata;
    guard = 0;
    in_data  = {bv[11:0], av[11:0]};
    in_valid = 1'b1;
    if (wc) begin
      coef_we   = 1'b1;
      coef_addr = ca[4:0];
      coef_data = cd[15:0];
    end
    do begin
      w = in_ready;
      tick();
      guard++;
    end while (!w && guard < 500);
    if (!w) begin
      checks++;
      errs++;
      $display("FAIL accept timeout: got in_ready=0 expected 1 within 500 cycles");
    end
    in_valid = 1'b0;
    coef_we  = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic write_coef(input int k, input int v);
    logic [31:0] kv, vv;
    kv = k; vv = v;
    coef_we   = 1'b1;
    coef_addr = kv[4:0];
    coef_data = vv[15:0];
    tick();
    coef_we = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((q.size() != 0 || busy) && g < 2000) begin
      tick();
      g++;
    end
    checks++;
    if (g >= 2000) begin
      errs++;
      $display("FAIL drain timeout: got %0d pending expected 0", q.size());
    end
    repeat (3) tick();
  endtask

  function automatic int rnd_s12();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  function automatic int rnd_s16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // default coefficients: pass-through, back-to-back vectors
    for (int i = 0; i < 16; i++) send(1000, -500, 0, 1'b0, 0, 0);
    wait_idle();

    // impulse response with ramp coefficients
    for (int k = 0; k < N_TAPS; k++) write_coef(k, (k + 1) * 1024);
    for (int i = 0; i < 40; i++) send(0, 0, 0, 1'b0, 0, 0);
    send(100, -100, 0, 1'b0, 0, 0);
    for (int i = 0; i < 39; i++) send(0, 0, 0, 1'b0, 0, 0);
    wait_idle();

    // DC gain of 1
    for (int k = 0; k < N_TAPS; k++) write_coef(k, 1024);
    for (int i = 0; i < 40; i++) send(1000, 1000, 1, 1'b0, 0, 0);
    wait_idle();

    // saturation in both directions
    for (int k = 0; k < N_TAPS; k++) write_coef(k, 32767);
    for (int i = 0; i < 40; i++) send(2047, -2048, 0, 1'b0, 0, 0);
    for (int i = 0; i < 40; i++) send(-2048, 2047, 0, 1'b0, 0, 0);
    wait_idle();

    // random coefficients and data, random gaps, occasional coefficient writes
    for (int k = 0; k < N_TAPS; k++) write_coef(k, rnd_s16());
    for (int i = 0; i < 200; i++)
      send(rnd_s12(), rnd_s12(), int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 31)), rnd_s16());
    wait_idle();

    // coefficient write while busy must be ignored
    for (int i = 0; i < 4; i++) send(rnd_s12(), rnd_s12(), 0, 1'b0, 0, 0);
    repeat (10) tick();
    write_coef(3, 12345);
    write_coef(0, -7777);
    for (int i = 0; i < 8; i++) send(rnd_s12(), rnd_s12(), 0, 1'b0, 0, 0);
    wait_idle();

    // reset ten cycles into a pass
    for (int i = 0; i < 4; i++) send(rnd_s12(), rnd_s12(), 0, 1'b0, 0, 0);
    repeat (10) tick();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) send(rnd_s12(), rnd_s12(), 0, 1'b0, 0, 0);
    wait_idle();

    repeat (20) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1000000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
